// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: address/data widths,
// the arbiter state encoding and the registered write record.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 4;

    typedef enum logic {
        WB_PRIO  = 1'b0,
        LL_FORCE = 1'b1
    } arb_state_t;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;

    typedef struct packed {
        logic      we;
        reg_addr_t dest;
        data_t     data;
    } rf_write_t;

    // Register 0 is hard-wired: writes to it are swallowed.
    function automatic logic writes_reg(input reg_addr_t dest);
        return dest != '0;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of WB, mult/div result, decode and register-file signals around the
// write arbiter. The arbiter is the slave; the pipeline/bench side is master.
interface rf_write_arbiter_if;
    import rf_pkg::*;

    // LL handshake: a result transfers on a cycle where ll_valid and ll_ready
    // are both high; ll_valid, ll_dest and ll_data must stay stable until then.
    logic       wb_en;
    reg_addr_t  wb_dest;
    data_t      wb_data;

    logic       ll_valid;
    reg_addr_t  ll_dest;
    data_t      ll_data;
    logic       ll_ready;

    logic       issue_en;
    reg_addr_t  issue_dest;
    reg_addr_t  src1;
    reg_addr_t  src2;
    logic       hazard1;
    logic       hazard2;

    logic       stall;
    logic       issue_conflict;

    logic       rf_we;
    reg_addr_t  rf_dest;
    data_t      rf_wdata;

    arb_state_t       state;
    logic [CNT_W-1:0] starve_cnt;

    modport master (
        output wb_en, wb_dest, wb_data,
        output ll_valid, ll_dest, ll_data,
        input  ll_ready,
        output issue_en, issue_dest, src1, src2,
        input  hazard1, hazard2, stall, issue_conflict,
        input  rf_we, rf_dest, rf_wdata,
        input  state, starve_cnt
    );

    modport slave (
        input  wb_en, wb_dest, wb_data,
        input  ll_valid, ll_dest, ll_data,
        output ll_ready,
        input  issue_en, issue_dest, src1, src2,
        output hazard1, hazard2, stall, issue_conflict,
        output rf_we, rf_dest, rf_wdata,
        output state, starve_cnt
    );

endinterface

// File: rtl/rf_write_arbiter_scoreboard.sv
// Pending-destination scoreboard: one bit per register still owed a
// long-latency result, with same-cycle set-over-clear and conflict detection.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      issue_en,
    input  reg_addr_t issue_dest,
    input  logic      clr_en,
    input  reg_addr_t clr_dest,
    input  reg_addr_t src1,
    input  reg_addr_t src2,
    output logic      hazard1,
    output logic      hazard2,
    output logic      issue_conflict
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic                set_en;
    logic                conflict_next;

    function automatic logic in_range(input reg_addr_t r);
        return int'(r) < NUM_REGS;
    endfunction

    function automatic logic lookup(input logic [NUM_REGS-1:0] vec, input reg_addr_t r);
        return in_range(r) ? vec[r] : 1'b0;
    endfunction

    // Clear is applied before set so an issue in the same cycle as the
    // matching LL acceptance leaves the register pending.
    always_comb begin
        pending_next  = pending;
        set_en        = issue_en && writes_reg(issue_dest) && in_range(issue_dest);
        conflict_next = set_en && pending[issue_dest];
        if (clr_en && in_range(clr_dest)) begin
            pending_next[clr_dest] = 1'b0;
        end
        if (set_en) begin
            pending_next[issue_dest] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending        <= '0;
            issue_conflict <= 1'b0;
        end else begin
            pending        <= pending_next;
            issue_conflict <= conflict_next;
        end
    end

    // Lookups use the registered vector, so a same-cycle issue shows up next cycle.
    assign hazard1 = ~rst & lookup(pending, src1);
    assign hazard2 = ~rst & lookup(pending, src2);

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and
// the mult/div unit, forcing the LL result through after STARVE_LIMIT denials.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic clk,
    input logic rst,
    rf_write_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             ll_ready;
    logic             stall;
    logic             ll_fire;
    logic             wb_fire;
    rf_write_t        wr_next;
    rf_write_t        wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WB_PRIO;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = '0;
        ll_ready   = 1'b0;
        stall      = 1'b0;
        case (state)
            WB_PRIO: begin
                ll_ready = bus.ll_valid & ~bus.wb_en;
                if (bus.ll_valid && !ll_ready) begin
                    cnt_next = cnt + CNT_W'(1);
                end
                if (cnt_next == LIMIT) begin
                    state_next = LL_FORCE;
                end
            end
            LL_FORCE: begin
                ll_ready   = bus.ll_valid;
                stall      = bus.wb_en;
                state_next = WB_PRIO;
            end
            default: begin
                state_next = WB_PRIO;
            end
        endcase
        // Nothing may be accepted in a reset cycle.
        if (rst) begin
            ll_ready = 1'b0;
            stall    = 1'b0;
        end
    end

    always_comb begin
        ll_fire = bus.ll_valid & ll_ready;
        wb_fire = bus.wb_en & ~stall & ~ll_fire;
        wr_next = '0;
        if (ll_fire) begin
            wr_next.we   = writes_reg(bus.ll_dest);
            wr_next.dest = bus.ll_dest;
            wr_next.data = bus.ll_data;
        end else if (wb_fire) begin
            wr_next.we   = writes_reg(bus.wb_dest);
            wr_next.dest = bus.wb_dest;
            wr_next.data = bus.wb_data;
        end
    end

    // Address/data hold their last value between writes; only we drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
        end else if (ll_fire || wb_fire) begin
            wr_q <= wr_next;
        end else begin
            wr_q.we <= 1'b0;
        end
    end

    rf_scoreboard #(
        .NUM_REGS(NUM_REGS)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .issue_en      (bus.issue_en),
        .issue_dest    (bus.issue_dest),
        .clr_en        (ll_fire),
        .clr_dest      (bus.ll_dest),
        .src1          (bus.src1),
        .src2          (bus.src2),
        .hazard1       (bus.hazard1),
        .hazard2       (bus.hazard2),
        .issue_conflict(bus.issue_conflict)
    );

    assign bus.ll_ready   = ll_ready;
    assign bus.stall      = stall;
    assign bus.rf_we      = wr_q.we;
    assign bus.rf_dest    = wr_q.dest;
    assign bus.rf_wdata   = wr_q.data;
    assign bus.state      = state;
    assign bus.starve_cnt = cnt;

    a_ready_needs_valid: assert property (@(posedge clk) ll_ready |-> bus.ll_valid);
    a_single_source: assert property (@(posedge clk) !(ll_fire && wb_fire));
    a_force_one_cycle: assert property (@(posedge clk) disable iff (rst)
        state == LL_FORCE |=> state == WB_PRIO);
    a_cnt_bounded: assert property (@(posedge clk) cnt <= LIMIT);
    a_no_r0_write: assert property (@(posedge clk) wr_q.we |-> wr_q.dest != '0);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a vector table for single-cycle
// behaviour plus hand-written starvation and reset-during-force sequences.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [36:0] exp_q[$];
    logic [36:0] exp_w;

    rf_write_arbiter_if bus_if();

    rf_write_arbiter #(.NUM_REGS(32), .STARVE_LIMIT(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wb_en;
        logic [4:0]  wb_dest;
        logic [31:0] wb_data;
        logic        ll_valid;
        logic [4:0]  ll_dest;
        logic [31:0] ll_data;
        logic        issue_en;
        logic [4:0]  issue_dest;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic        e_ll_ready;
        logic        e_stall;
        logic        e_h1;
        logic        e_h2;
        logic        e_we;
        logic [4:0]  e_dest;
        logic [31:0] e_data;
        logic        e_conflict;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mkv(
        input logic wb_en, input logic [4:0] wb_dest, input logic [31:0] wb_data,
        input logic ll_valid, input logic [4:0] ll_dest, input logic [31:0] ll_data,
        input logic issue_en, input logic [4:0] issue_dest,
        input logic [4:0] src1, input logic [4:0] src2,
        input logic e_ll_ready, input logic e_stall, input logic e_h1, input logic e_h2,
        input logic e_we, input logic [4:0] e_dest, input logic [31:0] e_data,
        input logic e_conflict);
        vec_t v;
        v.wb_en = wb_en;  v.wb_dest = wb_dest;  v.wb_data = wb_data;
        v.ll_valid = ll_valid;  v.ll_dest = ll_dest;  v.ll_data = ll_data;
        v.issue_en = issue_en;  v.issue_dest = issue_dest;
        v.src1 = src1;  v.src2 = src2;
        v.e_ll_ready = e_ll_ready;  v.e_stall = e_stall;  v.e_h1 = e_h1;  v.e_h2 = e_h2;
        v.e_we = e_we;  v.e_dest = e_dest;  v.e_data = e_data;  v.e_conflict = e_conflict;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus_if.wb_en      = v.wb_en;
        bus_if.wb_dest    = v.wb_dest;
        bus_if.wb_data    = v.wb_data;
        bus_if.ll_valid   = v.ll_valid;
        bus_if.ll_dest    = v.ll_dest;
        bus_if.ll_data    = v.ll_data;
        bus_if.issue_en   = v.issue_en;
        bus_if.issue_dest = v.issue_dest;
        bus_if.src1       = v.src1;
        bus_if.src2       = v.src2;
    endtask

    task automatic idle();
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic to_post_edge();
        @(posedge clk);
        #1;
    endtask

    // Every rf write is popped against the expected-write queue.
    always @(posedge clk) begin
        #1;
        if (bus_if.rf_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rf_write: got r%0d=0x%0h, required no write",
                         bus_if.rf_dest, bus_if.rf_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({bus_if.rf_dest, bus_if.rf_wdata} !== exp_w) begin
                    n_fail++;
                    $display("FAIL rf_write: got r%0d=0x%0h, required r%0d=0x%0h",
                             bus_if.rf_dest, bus_if.rf_wdata, exp_w[36:32], exp_w[31:0]);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset held two cycles with every request active.
        rst = 1'b1;
        drive(mkv(1, 5, 32'h1111, 1, 6, 32'h2222, 1, 4, 4, 9, 0, 0, 0, 0, 0, 0, 0, 0));
        to_post_edge();
        @(negedge clk);
        check("rst ll_ready", 32'(bus_if.ll_ready), 0);
        check("rst stall", 32'(bus_if.stall), 0);
        check("rst hazard1", 32'(bus_if.hazard1), 0);
        check("rst hazard2", 32'(bus_if.hazard2), 0);
        to_post_edge();
        check("rst rf_we", 32'(bus_if.rf_we), 0);
        check("rst rf_dest", 32'(bus_if.rf_dest), 0);
        check("rst rf_wdata", bus_if.rf_wdata, 0);
        check("rst conflict", 32'(bus_if.issue_conflict), 0);
        check("rst state", 32'(bus_if.state), 32'(WB_PRIO));
        check("rst starve_cnt", 32'(bus_if.starve_cnt), 0);
        rst = 1'b0;

        //              wb_en dst data       llv dst data       iss dst s1 s2 rdy stl h1 h2 we dst data      cf
        tbl[0]  = mkv(1, 5, 32'h1234, 0, 0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234, 0);
        tbl[1]  = mkv(0, 0, 32'h0,    0, 0, 32'h0,    1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0);
        tbl[2]  = mkv(0, 0, 32'h0,    1, 7, 32'hCAFE, 0, 0, 7, 0, 1, 0, 1, 0, 1, 7, 32'hCAFE, 0);
        tbl[3]  = mkv(0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0);
        tbl[4]  = mkv(0, 0, 32'h0,    0, 0, 32'h0,    1, 9, 9, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0);
        tbl[5]  = mkv(1, 2, 32'h22,   0, 0, 32'h0,    0, 0, 9, 7, 0, 0, 1, 0, 1, 2, 32'h22,   0);
        tbl[6]  = mkv(0, 0, 32'h0,    1, 9, 32'h99,   1, 9, 9, 0, 1, 0, 1, 0, 1, 9, 32'h99,   1);
        tbl[7]  = mkv(0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 9, 0, 0, 0, 1, 0, 0, 0, 32'h0,    0);
        tbl[8]  = mkv(0, 0, 32'h0,    1, 9, 32'h77,   0, 0, 9, 0, 1, 0, 1, 0, 1, 9, 32'h77,   0);
        tbl[9]  = mkv(1, 0, 32'h55,   0, 0, 32'h0,    0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0);
        tbl[10] = mkv(0, 0, 32'h0,    0, 0, 32'h0,    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0);
        tbl[11] = mkv(0, 0, 32'h0,    0, 0, 32'h0,    1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0);
        tbl[12] = mkv(0, 0, 32'h0,    0, 0, 32'h0,    1, 3, 0, 3, 0, 0, 0, 1, 0, 0, 32'h0,    1);
        tbl[13] = mkv(0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 32'h0,    0);
        tbl[14] = mkv(0, 0, 32'h0,    1, 3, 32'h33,   0, 0, 0, 3, 1, 0, 0, 1, 1, 3, 32'h33,   0);
        tbl[15] = mkv(1, 6, 32'h66,   1, 4, 32'h44,   0, 0, 0, 3, 0, 0, 0, 0, 1, 6, 32'h66,   0);
        tbl[16] = mkv(0, 0, 32'h0,    1, 4, 32'h44,   0, 0, 0, 0, 1, 0, 0, 0, 1, 4, 32'h44,   0);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i]);
            if (tbl[i].e_we) exp_q.push_back({tbl[i].e_dest, tbl[i].e_data});
            @(negedge clk);
            check($sformatf("v%0d ll_ready", i), 32'(bus_if.ll_ready), 32'(tbl[i].e_ll_ready));
            check($sformatf("v%0d stall", i), 32'(bus_if.stall), 32'(tbl[i].e_stall));
            check($sformatf("v%0d hazard1", i), 32'(bus_if.hazard1), 32'(tbl[i].e_h1));
            check($sformatf("v%0d hazard2", i), 32'(bus_if.hazard2), 32'(tbl[i].e_h2));
            to_post_edge();
            check($sformatf("v%0d rf_we", i), 32'(bus_if.rf_we), 32'(tbl[i].e_we));
            check($sformatf("v%0d conflict", i), 32'(bus_if.issue_conflict), 32'(tbl[i].e_conflict));
            if (tbl[i].e_we) begin
                check($sformatf("v%0d rf_dest", i), 32'(bus_if.rf_dest), 32'(tbl[i].e_dest));
                check($sformatf("v%0d rf_wdata", i), bus_if.rf_wdata, tbl[i].e_data);
            end
        end

        // Starvation: WB busy every cycle while an LL result waits.
        for (int k = 0; k < 4; k++) begin
            drive(mkv(1, 10, 32'h100 + k, 1, 11, 32'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            exp_q.push_back({5'd10, 32'h100 + k});
            @(negedge clk);
            check($sformatf("starve%0d ll_ready", k), 32'(bus_if.ll_ready), 0);
            check($sformatf("starve%0d stall", k), 32'(bus_if.stall), 0);
            to_post_edge();
            check($sformatf("starve%0d cnt", k), 32'(bus_if.starve_cnt), k + 1);
        end
        check("starve state", 32'(bus_if.state), 32'(LL_FORCE));
        drive(mkv(1, 10, 32'h200, 1, 11, 32'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back({5'd11, 32'hBEEF});
        @(negedge clk);
        check("force ll_ready", 32'(bus_if.ll_ready), 1);
        check("force stall", 32'(bus_if.stall), 1);
        to_post_edge();
        check("force rf_dest", 32'(bus_if.rf_dest), 11);
        check("force exit state", 32'(bus_if.state), 32'(WB_PRIO));
        check("force exit cnt", 32'(bus_if.starve_cnt), 0);
        drive(mkv(1, 10, 32'h200, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back({5'd10, 32'h200});
        @(negedge clk);
        check("held wb stall", 32'(bus_if.stall), 0);
        to_post_edge();
        check("held wb rf_dest", 32'(bus_if.rf_dest), 10);
        check("held wb rf_wdata", bus_if.rf_wdata, 32'h200);

        // Reset arriving in the LL_FORCE cycle discards the LL handshake.
        drive(mkv(0, 0, 32'h0, 0, 0, 32'h0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        to_post_edge();
        for (int k = 0; k < 4; k++) begin
            drive(mkv(1, 13, 32'h300 + k, 1, 12, 32'hDEAD, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            exp_q.push_back({5'd13, 32'h300 + k});
            @(negedge clk);
            check($sformatf("rstf%0d hazard1", k), 32'(bus_if.hazard1), 1);
            check($sformatf("rstf%0d ll_ready", k), 32'(bus_if.ll_ready), 0);
            to_post_edge();
        end
        check("rstf pre state", 32'(bus_if.state), 32'(LL_FORCE));
        rst = 1'b1;
        @(negedge clk);
        check("rstf ll_ready", 32'(bus_if.ll_ready), 0);
        check("rstf stall", 32'(bus_if.stall), 0);
        to_post_edge();
        rst = 1'b0;
        check("rstf rf_we", 32'(bus_if.rf_we), 0);
        check("rstf state", 32'(bus_if.state), 32'(WB_PRIO));
        check("rstf cnt", 32'(bus_if.starve_cnt), 0);
        drive(mkv(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("rstf pending cleared", 32'(bus_if.hazard1), 0);
        to_post_edge();
        check("rstf idle rf_we", 32'(bus_if.rf_we), 0);

        idle();
        to_post_edge();
        to_post_edge();
        check("exp_q drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between the in-order writeback stage and the multi-cycle mult/div unit. It also keeps a pending-destination scoreboard so decode can detect reads of registers still owed a long-latency result. The block sits between the WB stage, the mult/div result interface and the register file write inputs. It drives a stall to the pipeline when the long-latency unit must be forced through.

## Interface
Parameters:
- NUM_REGS, 32: architectural registers; scoreboard width.
- STARVE_LIMIT, 4: consecutive denied cycles before the LL unit is forced through; legal range 1..15.

Ports:
- clk, in, 1: clock; all state updates on rising edge.
- rst, in, 1: reset, synchronous, active-high.
- wb_en, in, 1: WB stage requests a write this cycle.
- wb_dest, in, 5: WB destination register.
- wb_data, in, 32: WB write value.
- ll_valid, in, 1: mult/div result available; must hold with dest/data until ll_ready.
- ll_dest, in, 5: LL destination register.
- ll_data, in, 32: LL write value.
- ll_ready, out, 1: LL result accepted this cycle (combinational).
- issue_en, in, 1: decode issues an LL op this cycle.
- issue_dest, in, 5: destination of the issued LL op.
- src1, src2, in, 5 each: decode source registers.
- hazard1, hazard2, out, 1 each: the source register has a pending LL write (combinational from scoreboard).
- stall, out, 1: pipeline must freeze; WB holds wb_en/wb_dest/wb_data.
- issue_conflict, out, 1: registered one-cycle pulse; an issue targeted an already-pending register.
- rf_we, out, 1: register file write enable, registered.
- rf_dest, out, 5: register file write address, registered.
- rf_wdata, out, 32: register file write data, registered.

## Operation
- FSM has two states.
  - WB_PRIO (reset state): WB wins whenever wb_en=1. ll_ready = ll_valid & ~wb_en.
  - LL_FORCE: ll_ready = ll_valid. stall = wb_en. WB is not written this cycle.
- Starvation counter (4 bits) behaviour in WB_PRIO:
  - Increments on each cycle with ll_valid & ~ll_ready.
  - Clears on any LL acceptance, or when ll_valid=0.
  - When it reaches STARVE_LIMIT, the next state is LL_FORCE.
- LL_FORCE lasts exactly one cycle, then returns to WB_PRIO with the counter cleared.
  - If ll_valid dropped in the meantime (protocol violation), the state still returns; no write occurs.
- Winner selection: the write source is LL if ll_valid & ll_ready, else WB if wb_en & ~stall, else none.
- Writes to register 0 are accepted (handshake completes) but produce rf_we=0.
- Scoreboard is a NUM_REGS-bit pending vector.
  - Set bit issue_dest on issue_en when issue_dest≠0.
  - Clear bit ll_dest on LL acceptance.
  - Simultaneous set and clear of the same register: set wins.
  - Issue to an already-pending register: the bit stays set, and issue_conflict pulses the next cycle.
- hazardN = pending[srcN]. A same-cycle issue is not visible until the next cycle. Bit 0 is always 0.

## Timing
- Reset values:
  - rf_we=0, rf_dest=0, rf_wdata=0, issue_conflict=0.
  - Pending vector all 0, counter 0, state WB_PRIO.
  - Therefore hazard1/2=0, stall=0 and ll_ready=0 during and after reset until inputs request.
- Write latency: the winner is sampled at edge N and appears on rf_* after edge N.
  - The register file commits it on the following falling edge.
  - The pending bit clears at the same rising edge, so decode reads after that falling edge see the new value.
- rst asserted mid-operation: all state is reset at that edge. Any in-flight LL handshake in that cycle is ignored, and no rf write is emitted.
- Only one rf write per cycle, ever.
- Worst-case LL wait is STARVE_LIMIT+1 cycles from ll_valid.

## Structure
- Shared package rf_pkg holds:
  - REG_ADDR_W=5, DATA_W=32.
  - The arb_state_t enum {WB_PRIO, LL_FORCE}.
- One natural sub-module: rf_scoreboard, containing the pending vector, set/clear/conflict logic and the two hazard lookups.
- Arbiter FSM, counter and output registers stay in the top.

## Test plan
- Reset: hold rst 2 cycles with all requests active -> rf_we=0, hazards 0, ll_ready=0; first post-reset wb_en to r5=0x1234 -> rf_we=1, rf_dest=5, rf_wdata=0x1234 one cycle later.
- Idle WB: ll_valid with ll_dest=7, data=0xCAFE, wb_en=0 -> ll_ready same cycle; rf write r7=0xCAFE next cycle; pending[7] cleared.
- Starvation, STARVE_LIMIT=4: wb_en=1 continuously and ll_valid held -> ll_ready=0 for 4 cycles; 5th cycle ll_ready=1, stall=1, only the LL write emitted; 6th cycle the held WB write emitted.
- Scoreboard: issue r9, then src1=9 -> hazard1=1 from next cycle until the LL write to r9 is accepted; hazard1=0 after that edge. Issue r9 and accept LL r9 in the same cycle -> pending[9] stays 1.
- Register 0 and conflict: wb_en to r0 -> rf_we=0. Issue r0 -> no pending bit. Issue r3 twice -> issue_conflict pulses one cycle.
- rst mid-force: assert rst in the LL_FORCE cycle -> no rf write, ll_dest's pending bit cleared, state WB_PRIO, counter 0.
